// File: rtl/ghostbus_host_seq.sv
// Host-side ghostbus initiator: turns a valid/ready command stream into ghostbus strobes.
// Latency: the strobe comes 1 cycle after accept; a read beat takes RD_LAT+2 cycles minimum.
// Backpressure: cmd_ready is high only in IDLE. A pending response (rsp_valid & !rsp_ready)
// holds rsp_data/rsp_last and stops further strobes.
//
// Ports:
//   clk, rst                  single clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; cmd_we, cmd_addr, cmd_wdata, cmd_len
//   rsp_valid/rsp_ready       read-data handshake; rsp_data, rsp_last
//   busy                      high whenever the sequencer is not idle
//   gb_addr, gb_wdata         registered ghostbus address/data, held between strobes
//   gb_we, gb_re              one-cycle write/read strobes
//   gb_rdata                  ghostbus read data, valid RD_LAT cycles after gb_re
module ghostbus_host_seq #(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int LW     = 8,
  parameter int RD_LAT = 1     // 1..15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [LW-1:0] cmd_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          busy,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_we,
  output logic          gb_re,
  input  logic [DW-1:0] gb_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RSP
  } state_t;

  localparam logic [3:0] LP_LAT = 4'(RD_LAT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_base;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_beat;
  logic [3:0]    r_lat;
  logic [AW-1:0] r_gb_addr;
  logic [DW-1:0] r_gb_wdata;
  logic [DW-1:0] r_rsp_data;
  logic          r_rsp_valid;
  logic          r_rsp_last;

  logic          w_accept;
  logic          w_rsp_hs;
  logic          w_lat_done;
  logic [LW-1:0] w_beat_inc;

  assign w_accept   = cmd_valid && (r_state == S_IDLE);
  assign w_rsp_hs   = r_rsp_valid && rsp_ready;
  // lat_cnt reaches 1 on exactly the cycle gb_rdata is valid
  assign w_lat_done = (r_state == S_RD_WAIT) && (r_lat == 4'd1);
  // Only used when beat_cnt < len, so it cannot overflow LW bits
  assign w_beat_inc = r_beat + 1'b1;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_state_nxt = cmd_we ? S_WR : S_RD_ISSUE;
      S_WR:       w_state_nxt = S_IDLE;
      S_RD_ISSUE: w_state_nxt = S_RD_WAIT;
      S_RD_WAIT:  if (w_lat_done) w_state_nxt = S_RSP;
      S_RSP:      if (w_rsp_hs) w_state_nxt = r_rsp_last ? S_IDLE : S_RD_ISSUE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath. gb_addr is loaded on the way into WR/RD_ISSUE, so the address is
  // already stable during the strobe cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_lat       <= '0;
      r_gb_addr   <= '0;
      r_gb_wdata  <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_base    <= cmd_addr;
            r_len     <= cmd_len;
            r_beat    <= '0;
            r_gb_addr <= cmd_addr;
            if (cmd_we) r_gb_wdata <= cmd_wdata;
          end
        end
        S_RD_ISSUE: begin
          r_lat <= LP_LAT;
        end
        S_RD_WAIT: begin
          if (w_lat_done) begin
            r_rsp_data  <= gb_rdata;
            r_rsp_valid <= 1'b1;
            r_rsp_last  <= (r_beat == r_len);
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        S_RSP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            if (!r_rsp_last) begin
              r_beat    <= w_beat_inc;
              // modulo 2^AW: bursts wrap from all-ones to zero
              r_gb_addr <= r_base + AW'(w_beat_inc);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign gb_we     = (r_state == S_WR);
  assign gb_re     = (r_state == S_RD_ISSUE);
  assign gb_addr   = r_gb_addr;
  assign gb_wdata  = r_gb_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_ghostbus_host_seq.sv
// Directed testbench for ghostbus_host_seq (RD_LAT=2) with a RAM model returning addr^0xA5.
// Latency: the model drives gb_rdata exactly RD_LAT cycles after gb_re and drives garbage otherwise.
// Backpressure: rsp_ready is driven per test; cmd_valid is held until accepted.
module tb_ghostbus_host_seq;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int LW = 8;
  localparam int RD_LAT = 2;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [LW-1:0] cmd_len;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          busy;
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata;
  logic          gb_we;
  logic          gb_re;
  logic [DW-1:0] gb_rdata;

  int checks = 0;
  int errors = 0;

  ghostbus_host_seq #(.AW(AW), .DW(DW), .LW(LW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_we(gb_we), .gb_re(gb_re),
    .gb_rdata(gb_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: two-stage pipeline, so data appears RD_LAT=2 cycles after gb_re
  logic [DW-1:0] p1, p2;
  always @(posedge clk) begin
    p1 <= gb_re ? ({8'h00, gb_addr} ^ 32'h0000_00A5) : 32'hBAD0_BAD0;
    p2 <= p1;
  end
  assign gb_rdata = p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled mid-cycle
  logic [AW-1:0] we_addr_q[$];
  logic [DW-1:0] we_data_q[$];
  logic [AW-1:0] re_addr_q[$];
  int            re_cyc_q[$];
  logic          acc_we_q[$];
  int            acc_cyc_q[$];
  logic [DW-1:0] rsp_data_q[$];
  logic          rsp_last_q[$];
  int            hs_cyc_q[$];
  int            viol = 0;
  logic          prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (gb_we) begin we_addr_q.push_back(gb_addr); we_data_q.push_back(gb_wdata); end
      if (gb_re) begin re_addr_q.push_back(gb_addr); re_cyc_q.push_back(cyc); end
      if ((gb_we || gb_re) && (prev_strobe || (gb_we && gb_re) || rsp_valid)) viol++;
      prev_strobe = gb_we || gb_re;
      if (cmd_valid && cmd_ready) begin acc_we_q.push_back(cmd_we); acc_cyc_q.push_back(cyc); end
      if (rsp_valid && rsp_ready) begin
        rsp_data_q.push_back(rsp_data); rsp_last_q.push_back(rsp_last); hs_cyc_q.push_back(cyc);
      end
    end else begin
      prev_strobe = 1'b0;
    end
  end

  function automatic logic [DW-1:0] ram(input logic [AW-1:0] a);
    return {8'h00, a} ^ 32'h0000_00A5;
  endfunction

  // Stimulus: present a command and hold it until accepted; returns at posedge+1 after accept
  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [LW-1:0] len);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = wd; cmd_len = len;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!ok) begin checks++; errors++; $display("FAIL send_cmd timeout addr=%h", a); end
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 200 && rsp_data_q.size() < target; i++) begin @(posedge clk); #1; end
    checks++;
    if (rsp_data_q.size() < target) begin
      errors++; $display("FAIL wait_rsp got=%0d want=%0d", rsp_data_q.size(), target);
    end
  endtask

  task automatic test_reset();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got=%b want=1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if ({gb_we, gb_re} !== 2'b00) begin errors++; $display("FAIL rst_strobes got=%b want=00", {gb_we, gb_re}); end
    checks++; if (gb_addr !== 24'h0) begin errors++; $display("FAIL rst_gb_addr got=%h want=0", gb_addr); end
    checks++; if (gb_wdata !== 32'h0) begin errors++; $display("FAIL rst_gb_wdata got=%h want=0", gb_wdata); end
    checks++; if ({rsp_data, rsp_last} !== 33'h0) begin errors++; $display("FAIL rst_rsp got=%h/%b want=0", rsp_data, rsp_last); end
  endtask

  task automatic test_write();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 24'h000010; cmd_wdata = 32'hceceface; cmd_len = 8'h0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_accept got=%b want=1", cmd_ready); end
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (gb_we !== 1'b1 || gb_re !== 1'b0) begin errors++; $display("FAIL wr_strobe got=%b%b want=10", gb_we, gb_re); end
    checks++; if (gb_addr !== 24'h000010) begin errors++; $display("FAIL wr_addr got=%h want=000010", gb_addr); end
    checks++; if (gb_wdata !== 32'hceceface) begin errors++; $display("FAIL wr_data got=%h want=ceceface", gb_wdata); end
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_busy got=%b%b want=01", cmd_ready, busy); end
    @(negedge clk);
    checks++; if (gb_we !== 1'b0) begin errors++; $display("FAIL wr_one_cycle got=%b want=0", gb_we); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_back got=%b want=1", cmd_ready); end
    checks++; if (gb_addr !== 24'h000010) begin errors++; $display("FAIL wr_addr_hold got=%h want=000010", gb_addr); end
    @(posedge clk); #1;
  endtask

  task automatic test_burst();
    int r0 = re_addr_q.size();
    int s0 = rsp_data_q.size();
    int a0;
    rsp_ready = 1'b1;
    send_cmd(1'b0, 24'h000100, 32'h0, 8'd3);
    a0 = acc_cyc_q[acc_cyc_q.size()-1];
    wait_rsp(s0 + 4);
    checks++; if (re_addr_q.size() - r0 !== 4) begin errors++; $display("FAIL burst_re_count got=%0d want=4", re_addr_q.size() - r0); end
    if (re_addr_q.size() - r0 >= 4) begin
      checks++; if (re_cyc_q[r0] - a0 !== 1) begin errors++; $display("FAIL burst_first_re got=%0d want=1", re_cyc_q[r0] - a0); end
      for (int i = 0; i < 4; i++) begin
        checks++; if (re_addr_q[r0+i] !== 24'h000100 + 24'(i)) begin
          errors++; $display("FAIL burst_addr[%0d] got=%h want=%h", i, re_addr_q[r0+i], 24'h000100 + 24'(i)); end
        if (i > 0) begin
          checks++; if (re_cyc_q[r0+i] - re_cyc_q[r0+i-1] !== RD_LAT + 2) begin
            errors++; $display("FAIL burst_beat_gap[%0d] got=%0d want=%0d", i, re_cyc_q[r0+i] - re_cyc_q[r0+i-1], RD_LAT + 2); end
        end
      end
    end
    if (rsp_data_q.size() - s0 >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (rsp_data_q[s0+i] !== ram(24'h000100 + 24'(i)) || rsp_last_q[s0+i] !== (i == 3)) begin
          errors++; $display("FAIL burst_rsp[%0d] got=%h/%b want=%h/%b", i, rsp_data_q[s0+i], rsp_last_q[s0+i], ram(24'h000100 + 24'(i)), i == 3); end
      end
    end
  endtask

  task automatic test_backpressure();
    int  s0 = rsp_data_q.size();
    int  h0 = hs_cyc_q.size();
    int  r_hold, bad = 0;
    bit  seen = 0;
    rsp_ready = 1'b0;
    send_cmd(1'b0, 24'h000200, 32'h0, 8'd1);
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); if (rsp_valid) seen = 1; end
    checks++; if (!seen) begin errors++; $display("FAIL bp_rsp_valid timeout"); end
    r_hold = re_addr_q.size();
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h000002A5 || rsp_last !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold_stable got=%0d bad cycles want=0", bad); end
    checks++; if (re_addr_q.size() !== r_hold) begin errors++; $display("FAIL bp_no_re got=%0d want=0", re_addr_q.size() - r_hold); end
    @(posedge clk); #1; rsp_ready = 1'b1;
    wait_rsp(s0 + 2);
    if (rsp_data_q.size() - s0 >= 2 && hs_cyc_q.size() - h0 >= 1) begin
      checks++; if (re_cyc_q[re_cyc_q.size()-1] - hs_cyc_q[h0] !== 1) begin
        errors++; $display("FAIL bp_re_after_hs got=%0d want=1", re_cyc_q[re_cyc_q.size()-1] - hs_cyc_q[h0]); end
      checks++; if (rsp_data_q[s0] !== 32'h000002A5 || rsp_data_q[s0+1] !== 32'h000002A4 || rsp_last_q[s0+1] !== 1'b1) begin
        errors++; $display("FAIL bp_data got=%h,%h/%b want=000002a5,000002a4/1", rsp_data_q[s0], rsp_data_q[s0+1], rsp_last_q[s0+1]); end
    end
  endtask

  task automatic test_wrap();
    int r0 = re_addr_q.size();
    int s0 = rsp_data_q.size();
    rsp_ready = 1'b1;
    send_cmd(1'b0, 24'hFFFFFF, 32'h0, 8'd1);
    wait_rsp(s0 + 2);
    if (re_addr_q.size() - r0 >= 2 && rsp_data_q.size() - s0 >= 2) begin
      checks++; if (re_addr_q[r0] !== 24'hFFFFFF || re_addr_q[r0+1] !== 24'h000000) begin
        errors++; $display("FAIL wrap_addr got=%h,%h want=ffffff,000000", re_addr_q[r0], re_addr_q[r0+1]); end
      checks++; if (rsp_data_q[s0] !== 32'h00FFFF5A || rsp_data_q[s0+1] !== 32'h000000A5) begin
        errors++; $display("FAIL wrap_data got=%h,%h want=00ffff5a,000000a5", rsp_data_q[s0], rsp_data_q[s0+1]); end
      checks++; if (rsp_last_q[s0] !== 1'b0 || rsp_last_q[s0+1] !== 1'b1) begin
        errors++; $display("FAIL wrap_last got=%b%b want=01", rsp_last_q[s0], rsp_last_q[s0+1]); end
    end
  endtask

  task automatic test_reset_mid();
    int r0, s0, w0;
    rsp_ready = 1'b1;
    send_cmd(1'b0, 24'h000300, 32'h0, 8'd3);   // returns in the RD_ISSUE cycle
    @(posedge clk); #1;                          // now in RD_WAIT
    checks++; if (busy !== 1'b1 || gb_re !== 1'b0) begin errors++; $display("FAIL mid_in_wait got=%b%b want=10", busy, gb_re); end
    rst = 1'b1; #1;
    checks++; if ({busy, rsp_valid, gb_we, gb_re, rsp_last} !== 5'b0 || gb_addr !== 24'h0 || gb_wdata !== 32'h0 || rsp_data !== 32'h0) begin
      errors++; $display("FAIL mid_async_clear got=%b%b%b%b%b %h %h %h want=0", busy, rsp_valid, gb_we, gb_re, rsp_last, gb_addr, gb_wdata, rsp_data); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready got=%b want=1", cmd_ready); end
    @(posedge clk); #1; rst = 1'b0;
    r0 = re_addr_q.size(); s0 = rsp_data_q.size(); w0 = we_addr_q.size();
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (re_addr_q.size() !== r0 || rsp_data_q.size() !== s0) begin
      errors++; $display("FAIL mid_aborted got=%0d re %0d rsp want=0", re_addr_q.size() - r0, rsp_data_q.size() - s0); end
    send_cmd(1'b1, 24'h000055, 32'h12345678, 8'd0);
    @(posedge clk); #1;
    checks++; if (we_addr_q.size() - w0 !== 1) begin errors++; $display("FAIL mid_wr_count got=%0d want=1", we_addr_q.size() - w0); end
    else begin
      checks++; if (we_addr_q[w0] !== 24'h000055 || we_data_q[w0] !== 32'h12345678) begin
        errors++; $display("FAIL mid_wr got=%h/%h want=000055/12345678", we_addr_q[w0], we_data_q[w0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic          t_we  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [AW-1:0] t_addr[5] = '{24'h400, 24'h401, 24'h402, 24'h403, 24'h404};
    logic [DW-1:0] t_wd  [5] = '{32'h11111111, 32'h0, 32'h22222222, 32'h0, 32'h33333333};
    logic [LW-1:0] t_len [5] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd0};
    int  idx = 0;
    int  a0 = acc_we_q.size(), w0 = we_addr_q.size(), r0 = re_addr_q.size(), s0 = rsp_data_q.size();
    bit  acc;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_we = t_we[0]; cmd_addr = t_addr[0]; cmd_wdata = t_wd[0]; cmd_len = t_len[0];
    for (int i = 0; i < 200 && idx < 5; i++) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 5) begin cmd_we = t_we[idx]; cmd_addr = t_addr[idx]; cmd_wdata = t_wd[idx]; cmd_len = t_len[idx]; end
      end
    end
    cmd_valid = 1'b0;
    wait_rsp(s0 + 3);
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (acc_we_q.size() - a0 !== 5) begin errors++; $display("FAIL b2b_accepts got=%0d want=5", acc_we_q.size() - a0); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (acc_we_q[a0+i] !== t_we[i]) begin errors++; $display("FAIL b2b_order[%0d] got=%b want=%b", i, acc_we_q[a0+i], t_we[i]); end
      end
    end
    checks++; if (we_addr_q.size() - w0 !== 3) begin errors++; $display("FAIL b2b_wr_count got=%0d want=3", we_addr_q.size() - w0); end
    else begin
      checks++; if (we_addr_q[w0] !== 24'h400 || we_addr_q[w0+1] !== 24'h402 || we_addr_q[w0+2] !== 24'h404 ||
                    we_data_q[w0] !== 32'h11111111 || we_data_q[w0+1] !== 32'h22222222 || we_data_q[w0+2] !== 32'h33333333) begin
        errors++; $display("FAIL b2b_writes got=%h/%h %h/%h %h/%h", we_addr_q[w0], we_data_q[w0], we_addr_q[w0+1], we_data_q[w0+1], we_addr_q[w0+2], we_data_q[w0+2]); end
    end
    checks++; if (re_addr_q.size() - r0 !== 3) begin errors++; $display("FAIL b2b_rd_count got=%0d want=3", re_addr_q.size() - r0); end
    else begin
      checks++; if (re_addr_q[r0] !== 24'h401 || re_addr_q[r0+1] !== 24'h403 || re_addr_q[r0+2] !== 24'h404) begin
        errors++; $display("FAIL b2b_rd_addr got=%h %h %h want=401 403 404", re_addr_q[r0], re_addr_q[r0+1], re_addr_q[r0+2]); end
    end
    checks++; if (rsp_data_q.size() - s0 !== 3) begin errors++; $display("FAIL b2b_rsp_count got=%0d want=3", rsp_data_q.size() - s0); end
    else begin
      checks++; if (rsp_data_q[s0] !== 32'h000004A4 || rsp_data_q[s0+1] !== 32'h000004A6 || rsp_data_q[s0+2] !== 32'h000004A1 ||
                    rsp_last_q[s0] !== 1'b1 || rsp_last_q[s0+1] !== 1'b0 || rsp_last_q[s0+2] !== 1'b1) begin
        errors++; $display("FAIL b2b_rsp got=%h/%b %h/%b %h/%b", rsp_data_q[s0], rsp_last_q[s0], rsp_data_q[s0+1], rsp_last_q[s0+1], rsp_data_q[s0+2], rsp_last_q[s0+2]); end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_len = '0; rsp_ready = 1'b0;
    #12;
    test_reset();
    @(posedge clk); #1; rst = 1'b0;
    test_write();
    test_burst();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    checks++; if (viol !== 0) begin errors++; $display("FAIL strobe_rules got=%0d violations want=0", viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
